// File: rtl/scene_pkg.sv
// Shared types and constants for the SPI frame sequencer.
//   opcode_t    : command opcode in recv_64bit[63:60]
//   seq_state_t : sequencer FSM state (also driven on led[1:0])
//   OBJ_W       : object record width
//   MAX_OBJECTS : default maximum objects per frame
package scene_pkg;

  localparam int unsigned OBJ_W       = 60;
  localparam int unsigned MAX_OBJECTS = 16;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_BEGIN  = 4'h1,
    OP_OBJECT = 4'h2,
    OP_END    = 4'h3
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_END = 2'd2,
    ARM      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Signal bundle between SPI receiver, MCU, scene memory and renderer.
//   master : sequencer side (consumes SPI words, drives scene/render/status)
//   slave  : environment side (SPI receiver, renderer, MCU)
interface spi_frame_sequencer_if #(
  parameter int unsigned MAX_OBJECTS = scene_pkg::MAX_OBJECTS,
  parameter int unsigned IDX_W       = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1
);
  logic                        recv_dv;
  logic [63:0]                 recv_64bit;
  logic                        recv_interrupt;
  logic                        scene_we;
  logic [IDX_W:0]              scene_waddr;
  logic [scene_pkg::OBJ_W-1:0] scene_wdata;
  logic                        render_bank;
  logic [7:0]                  render_count;
  logic                        frame_start;
  logic                        render_busy;
  logic                        err_clear;
  logic                        err_proto;
  logic [3:0]                  led;

  modport master (
    input  recv_dv, recv_64bit, render_busy, err_clear,
    output recv_interrupt, scene_we, scene_waddr, scene_wdata,
           render_bank, render_count, frame_start, err_proto, led
  );

  modport slave (
    output recv_dv, recv_64bit, render_busy, err_clear,
    input  recv_interrupt, scene_we, scene_waddr, scene_wdata,
           render_bank, render_count, frame_start, err_proto, led
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Decodes 64-bit SPI command words, loads object records into the write bank
// of a double-buffered scene memory, and on END hands the bank to the
// renderer (bank swap + frame_start) once the renderer is idle.
//   CLK100MHZ : system clock
//   ck_rst    : synchronous active-high reset
//   bus       : master modport (SPI word in, scene write port, render control,
//               recv_interrupt, err_proto/err_clear, led status)
module spi_frame_sequencer #(
  parameter int unsigned MAX_OBJECTS = scene_pkg::MAX_OBJECTS,
  parameter int unsigned IDX_W       = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  ck_rst,
  spi_frame_sequencer_if.master bus
);
  import scene_pkg::*;

  seq_state_t       state, state_n;
  logic             wr_bank, wr_bank_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       count, count_n;

  logic             recv_interrupt_n, scene_we_n, render_bank_n, frame_start_n, err_proto_n;
  logic [IDX_W:0]   scene_waddr_n;
  logic [OBJ_W-1:0] scene_wdata_n;
  logic [7:0]       render_count_n;
  logic [3:0]       led_n;

  logic [3:0]       op;
  logic [7:0]       begin_cnt;
  logic             begin_ok, last_obj, err_set;

  assign op        = bus.recv_64bit[63:60];
  assign begin_cnt = bus.recv_64bit[7:0];
  assign begin_ok  = (begin_cnt != 8'd0) && (32'(begin_cnt) <= MAX_OBJECTS);
  assign last_obj  = (9'(idx) == (9'(count) - 9'd1));

  always_comb begin
    state_n        = state;
    wr_bank_n      = wr_bank;
    idx_n          = idx;
    count_n        = count;
    scene_we_n     = 1'b0;
    scene_waddr_n  = bus.scene_waddr;
    scene_wdata_n  = bus.scene_wdata;
    render_bank_n  = bus.render_bank;
    render_count_n = bus.render_count;
    frame_start_n  = 1'b0;
    err_set        = 1'b0;

    if (bus.recv_dv) begin
      unique case (state)
        IDLE: begin
          if (op == OP_BEGIN && begin_ok) begin
            count_n = begin_cnt;
            idx_n   = '0;
            state_n = LOAD;
          end else if (op != OP_NOP) begin
            err_set = 1'b1;
          end
        end
        LOAD: begin
          if (op == OP_OBJECT) begin
            scene_we_n    = 1'b1;
            scene_waddr_n = {wr_bank, idx};
            scene_wdata_n = bus.recv_64bit[OBJ_W-1:0];
            idx_n         = idx + 1'b1;
            if (last_obj) state_n = WAIT_END;
          end else if (op != OP_NOP) begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
        WAIT_END: begin
          if (op == OP_END) begin
            state_n = ARM;
          end else if (op != OP_NOP) begin
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
        ARM: begin
          // Stray words are flagged but never disturb the armed frame.
          if (op != OP_NOP) err_set = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end

    if (state == ARM && !bus.render_busy) begin
      frame_start_n  = 1'b1;
      render_bank_n  = wr_bank;
      render_count_n = count;
      wr_bank_n      = ~wr_bank;
      state_n        = IDLE;
    end

    // Registered "sitting in IDLE": rises one cycle after entering IDLE and
    // drops together with the move out of IDLE.
    recv_interrupt_n = (state == IDLE) && (state_n == IDLE);
    // A new error outranks a simultaneous clear.
    err_proto_n      = err_set | (bus.err_proto & ~bus.err_clear);
    led_n            = {err_proto_n, wr_bank_n, state_n};
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state              <= IDLE;
      wr_bank            <= 1'b0;
      idx                <= '0;
      count              <= '0;
      bus.recv_interrupt <= 1'b0;
      bus.scene_we       <= 1'b0;
      bus.scene_waddr    <= '0;
      bus.scene_wdata    <= '0;
      bus.render_bank    <= 1'b0;
      bus.render_count   <= '0;
      bus.frame_start    <= 1'b0;
      bus.err_proto      <= 1'b0;
      bus.led            <= '0;
    end else begin
      state              <= state_n;
      wr_bank            <= wr_bank_n;
      idx                <= idx_n;
      count              <= count_n;
      bus.recv_interrupt <= recv_interrupt_n;
      bus.scene_we       <= scene_we_n;
      bus.scene_waddr    <= scene_waddr_n;
      bus.scene_wdata    <= scene_wdata_n;
      bus.render_bank    <= render_bank_n;
      bus.render_count   <= render_count_n;
      bus.frame_start    <= frame_start_n;
      bus.err_proto      <= err_proto_n;
      bus.led            <= led_n;
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: a vector table for the basic frame,
// then hand-written sequences for back-pressure, errors, aborts, NOPs, reset.
module tb_spi_frame_sequencer;
  import scene_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_sequencer_if #(.MAX_OBJECTS(16)) bus ();
  spi_frame_sequencer #(.MAX_OBJECTS(16)) dut (
    .CLK100MHZ (clk),
    .ck_rst    (rst),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  localparam logic [59:0] DA = 60'hAAAAAAAAAAAAAAA;
  localparam logic [59:0] DB = 60'h555555555555555;
  localparam logic [59:0] DC = 60'h123456789ABCDEF;
  localparam logic [59:0] DD = 60'h0DEADBEEF000001;
  localparam logic [59:0] DE = 60'hFEDCBA987654321;
  localparam logic [59:0] DF = 60'h00000000000F00F;

  typedef struct {
    logic        dv;
    logic [63:0] word;
    logic        busy;
    logic        clr;
    logic        we;
    logic [4:0]  addr;
    logic [59:0] data;
    logic        ri;
    logic        fs;
    logic        rb;
    logic [7:0]  rc;
    logic        err;
    logic [3:0]  led;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [63:0] cmd(input logic [3:0] op, input logic [59:0] p);
    return {op, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 ns after the edge.
  task automatic step(input logic dv, input logic [63:0] w, input logic busy, input logic clr);
    bus.recv_dv     = dv;
    bus.recv_64bit  = w;
    bus.render_busy = busy;
    bus.err_clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic e(input string t, input logic we, input logic [4:0] addr, input logic [59:0] data,
                   input logic ri, input logic fs, input logic rb, input logic [7:0] rc,
                   input logic err, input logic [3:0] led);
    chk({t, ".we"}, 64'(bus.scene_we), 64'(we));
    if (we) begin
      chk({t, ".waddr"}, 64'(bus.scene_waddr), 64'(addr));
      chk({t, ".wdata"}, 64'(bus.scene_wdata), 64'(data));
    end
    chk({t, ".recv_interrupt"}, 64'(bus.recv_interrupt), 64'(ri));
    chk({t, ".frame_start"}, 64'(bus.frame_start), 64'(fs));
    chk({t, ".render_bank"}, 64'(bus.render_bank), 64'(rb));
    chk({t, ".render_count"}, 64'(bus.render_count), 64'(rc));
    chk({t, ".err_proto"}, 64'(bus.err_proto), 64'(err));
    chk({t, ".led"}, 64'(bus.led), 64'(led));
  endtask

  task automatic all_zero(input string t);
    chk({t, ".we"}, 64'(bus.scene_we), 64'd0);
    chk({t, ".waddr"}, 64'(bus.scene_waddr), 64'd0);
    chk({t, ".wdata"}, 64'(bus.scene_wdata), 64'd0);
    chk({t, ".recv_interrupt"}, 64'(bus.recv_interrupt), 64'd0);
    chk({t, ".frame_start"}, 64'(bus.frame_start), 64'd0);
    chk({t, ".render_bank"}, 64'(bus.render_bank), 64'd0);
    chk({t, ".render_count"}, 64'(bus.render_count), 64'd0);
    chk({t, ".err_proto"}, 64'(bus.err_proto), 64'd0);
    chk({t, ".led"}, 64'(bus.led), 64'd0);
  endtask

  initial begin
    //          dv    word               busy  clr   we    addr   data   ri    fs    rb    rc     err   led
    tbl[0] = '{1'b0, 64'h0,            1'b0, 1'b0, 1'b0, 5'h00, 60'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0};
    tbl[1] = '{1'b1, cmd(4'h1, 60'd2), 1'b0, 1'b0, 1'b0, 5'h00, 60'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h1};
    tbl[2] = '{1'b1, cmd(4'h2, DA),    1'b0, 1'b0, 1'b1, 5'h00, DA,    1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h1};
    tbl[3] = '{1'b1, cmd(4'h2, DB),    1'b0, 1'b0, 1'b1, 5'h01, DB,    1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h2};
    tbl[4] = '{1'b1, cmd(4'h3, 60'd0), 1'b0, 1'b0, 1'b0, 5'h00, 60'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h3};
    tbl[5] = '{1'b0, 64'h0,            1'b0, 1'b0, 1'b0, 5'h00, 60'h0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 4'h4};
    tbl[6] = '{1'b0, 64'h0,            1'b0, 1'b0, 1'b0, 5'h00, 60'h0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 4'h4};

    bus.recv_dv     = 1'b0;
    bus.recv_64bit  = '0;
    bus.render_busy = 1'b0;
    bus.err_clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;

    // Basic cnt=2 frame into bank 0.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].dv, tbl[i].word, tbl[i].busy, tbl[i].clr);
      e($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ri,
        tbl[i].fs, tbl[i].rb, tbl[i].rc, tbl[i].err, tbl[i].led);
    end

    // Second frame (bank 1) while the renderer is busy; stray word in ARM.
    step(1, cmd(4'h1, 60'd1), 0, 0); e("f2.begin", 0, 0, 0, 0, 0, 0, 2, 0, 4'h5);
    step(1, cmd(4'h2, DC), 1, 0);    e("f2.obj", 1, 5'h10, DC, 0, 0, 0, 2, 0, 4'h6);
    step(1, cmd(4'h3, 0), 1, 0);     e("f2.end", 0, 0, 0, 0, 0, 0, 2, 0, 4'h7);
    step(0, 0, 1, 0);                e("f2.hold1", 0, 0, 0, 0, 0, 0, 2, 0, 4'h7);
    step(0, 0, 1, 0);                e("f2.hold2", 0, 0, 0, 0, 0, 0, 2, 0, 4'h7);
    step(1, cmd(4'h2, DC), 1, 0);    e("f2.stray", 0, 0, 0, 0, 0, 0, 2, 1, 4'hF);
    step(0, 0, 0, 0);                e("f2.commit", 0, 0, 0, 0, 1, 1, 1, 1, 4'h8);
    step(0, 0, 0, 1);                e("f2.after", 0, 0, 0, 1, 0, 1, 1, 0, 4'h0);

    // Bad BEGIN counts, clear, and error coincident with clear.
    step(1, cmd(4'h1, 60'd0), 0, 0);  e("err.cnt0", 0, 0, 0, 1, 0, 1, 1, 1, 4'h8);
    step(1, cmd(4'h1, 60'd17), 0, 0); e("err.cnt17", 0, 0, 0, 1, 0, 1, 1, 1, 4'h8);
    step(0, 0, 0, 1);                 e("err.clr", 0, 0, 0, 1, 0, 1, 1, 0, 4'h0);
    step(1, cmd(4'h1, 60'd0), 0, 1);  e("err.clr_vs_set", 0, 0, 0, 1, 0, 1, 1, 1, 4'h8);
    step(1, cmd(4'h3, 60'd0), 0, 1);  e("err.end_idle", 0, 0, 0, 1, 0, 1, 1, 1, 4'h8);
    step(0, 0, 0, 1);                 e("err.clr2", 0, 0, 0, 1, 0, 1, 1, 0, 4'h0);

    // Early END aborts; next frame reuses bank 0 from index 0.
    step(1, cmd(4'h1, 60'd3), 0, 0); e("ab.begin", 0, 0, 0, 0, 0, 1, 1, 0, 4'h1);
    step(1, cmd(4'h2, DD), 0, 0);    e("ab.obj", 1, 5'h00, DD, 0, 0, 1, 1, 0, 4'h1);
    step(1, cmd(4'h3, 0), 0, 0);     e("ab.end", 0, 0, 0, 0, 0, 1, 1, 1, 4'h8);
    step(0, 0, 0, 1);                e("ab.idle", 0, 0, 0, 1, 0, 1, 1, 0, 4'h0);
    step(1, cmd(4'h1, 60'd1), 0, 0); e("ab.begin2", 0, 0, 0, 0, 0, 1, 1, 0, 4'h1);
    step(1, cmd(4'h2, DE), 0, 0);    e("ab.obj2", 1, 5'h00, DE, 0, 0, 1, 1, 0, 4'h2);
    step(1, cmd(4'h3, 0), 0, 0);     e("ab.end2", 0, 0, 0, 0, 0, 1, 1, 0, 4'h3);
    step(0, 0, 0, 0);                e("ab.commit", 0, 0, 0, 0, 1, 0, 1, 0, 4'h4);
    step(0, 0, 0, 0);                e("ab.after", 0, 0, 0, 1, 0, 0, 1, 0, 4'h4);

    // NOPs interleaved in a cnt=2 frame (bank 1).
    step(1, cmd(4'h1, 60'd2), 0, 0); e("nop.begin", 0, 0, 0, 0, 0, 0, 1, 0, 4'h5);
    step(1, 64'h0, 0, 0);            e("nop.n1", 0, 0, 0, 0, 0, 0, 1, 0, 4'h5);
    step(1, cmd(4'h2, DA), 0, 0);    e("nop.obj0", 1, 5'h10, DA, 0, 0, 0, 1, 0, 4'h5);
    step(1, 64'h0, 0, 0);            e("nop.n2", 0, 0, 0, 0, 0, 0, 1, 0, 4'h5);
    step(1, cmd(4'h2, DB), 0, 0);    e("nop.obj1", 1, 5'h11, DB, 0, 0, 0, 1, 0, 4'h6);
    step(1, 64'h0, 0, 0);            e("nop.n3", 0, 0, 0, 0, 0, 0, 1, 0, 4'h6);
    step(1, cmd(4'h3, 0), 0, 0);     e("nop.end", 0, 0, 0, 0, 0, 0, 1, 0, 4'h7);
    step(1, 64'h0, 0, 0);            e("nop.commit", 0, 0, 0, 0, 1, 1, 2, 0, 4'h0);
    step(1, 64'h0, 0, 0);            e("nop.after", 0, 0, 0, 1, 0, 1, 2, 0, 4'h0);

    // Reset in the middle of LOAD.
    step(1, cmd(4'h1, 60'd2), 0, 0); e("rst.begin", 0, 0, 0, 0, 0, 1, 2, 0, 4'h1);
    step(1, cmd(4'h2, DF), 0, 0);    e("rst.obj", 1, 5'h00, DF, 0, 0, 1, 2, 0, 4'h1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    all_zero("rst.mid");
    rst = 1'b0;
    step(0, 0, 0, 0);                e("rst.idle", 0, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    step(1, cmd(4'h1, 60'd1), 0, 0); e("rst.begin2", 0, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    step(1, cmd(4'h2, DE), 0, 0);    e("rst.obj2", 1, 5'h00, DE, 0, 0, 0, 0, 0, 4'h2);
    step(1, cmd(4'h3, 0), 0, 0);     e("rst.end2", 0, 0, 0, 0, 0, 0, 0, 0, 4'h3);
    step(0, 0, 0, 0);                e("rst.commit", 0, 0, 0, 0, 1, 0, 1, 0, 4'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
Sits between SPI_Slave_64 and the raytracing renderer. It decodes the 64-bit command words received over SPI and loads object records into a double-buffered scene memory. When a frame is complete it swaps banks, pulses frame_start to the renderer, and drives recv_interrupt high to tell the MCU it can send the next frame.

Parameters:
MAX_OBJECTS, 16, maximum objects per frame (1..255).
IDX_W, $clog2(MAX_OBJECTS), object index width.
OBJ_W, 60, object record width (recv_64bit[59:0]).

Ports:
CLK100MHZ  in  1  system clock; the only clock.
ck_rst  in  1  reset, synchronous, active-high.
recv_dv  in  1  one-cycle strobe: recv_64bit is valid.
recv_64bit  in  64  command word; [63:60] opcode, [59:0] payload.
recv_interrupt  out  1  high = ready to accept a new frame.
scene_we  out  1  scene memory write strobe.
scene_waddr  out  IDX_W+1  {bank, index}.
scene_wdata  out  OBJ_W  object record.
render_bank  out  1  bank the renderer reads.
render_count  out  8  object count of the committed frame.
frame_start  out  1  one-cycle start pulse to the renderer.
render_busy  in  1  renderer is active; raised no later than 1 cycle after frame_start.
err_clear  in  1  clears err_proto.
err_proto  out  1  sticky protocol error.
led  out  4  {err_proto, wr_bank, state[1:0]}.

Behaviour:
- Opcodes:
  - 0x0 NOP: ignored in every state.
  - 0x1 BEGIN: payload[7:0] = object count.
  - 0x2 OBJECT: payload = object record.
  - 0x3 END: closes the frame.
  - 0x4–0xF: illegal.
- Registers: state, wr_bank, idx, count, plus all outputs. Every output is registered.
- Reset values: all outputs 0, state IDLE, wr_bank 0, idx 0, count 0. recv_interrupt goes to 1 on the first cycle after reset deasserts.
- States and encoding: IDLE=0, LOAD=1, WAIT_END=2, ARM=3.
- IDLE (recv_interrupt=1):
  - BEGIN with 1 ≤ count ≤ MAX_OBJECTS: latch count, idx←0, go to LOAD. recv_interrupt=0 from the next cycle.
  - BEGIN with count=0 or count>MAX_OBJECTS: set err_proto, stay in IDLE.
  - OBJECT or END: set err_proto, stay in IDLE.
- LOAD, on OBJECT:
  - In the next cycle, scene_we=1 for exactly 1 cycle, scene_waddr={wr_bank, idx}, scene_wdata=recv_64bit[59:0].
  - idx increments.
  - If idx==count-1, go to WAIT_END.
- WAIT_END:
  - END: go to ARM.
  - OBJECT (too many objects), BEGIN, or illegal opcode: abort.
- Abort rule (applies in LOAD and WAIT_END): BEGIN, END-too-early, or an illegal opcode sets err_proto and returns to IDLE. wr_bank is unchanged, render_* are unchanged, no frame_start; the partial data is simply overwritten by the next frame.
- ARM (recv_interrupt=0):
  - If render_busy==0 in a cycle, then in the next cycle: frame_start=1, render_bank←wr_bank, render_count←count, wr_bank←~wr_bank, state←IDLE.
  - If render_busy==1, hold in ARM indefinitely.
  - Any non-NOP word received in ARM sets err_proto but does not disturb the armed frame.
- Latency: END on cycle t → ARM at t+1 → frame_start at t+2 when render_busy=0 at t+1.
- err_proto: set by any error and cleared by err_clear. An error in the same cycle as err_clear wins, so err_proto stays 1.
- Reset mid-operation: immediate return to the reset values on the next edge. The in-progress frame is discarded, and render_bank/render_count return to 0.
- The renderer never reads bank wr_bank, so loading a frame while rendering is safe.

Decomposition:
- Package scene_pkg:
  - opcode_t enum (NOP, BEGIN, OBJECT, END).
  - seq_state_t enum (IDLE, LOAD, WAIT_END, ARM), 2 bits.
  - OBJ_W and MAX_OBJECTS constants.
- Single module, no sub-module. The scene RAM lives in the renderer.

Test Plan:
- Reset; BEGIN cnt=2, OBJECT 0xAAA…, OBJECT 0x555…, END, render_busy=0 → writes addr 0/1 with those data; frame_start 2 cycles after END; render_bank=0, render_count=2, wr_bank=1; recv_interrupt=1 the cycle after frame_start.
- Second frame (cnt=1) while render_busy=1 → writes addr {1,0}; FSM holds in ARM with recv_interrupt=0; drop render_busy → frame_start the next cycle, render_bank=1.
- BEGIN cnt=0, then BEGIN cnt=17 → err_proto=1, no scene_we, state IDLE; err_clear → err_proto=0. Repeat with err_clear coincident with a new error → err_proto stays 1.
- BEGIN cnt=3, one OBJECT, END → err_proto=1, IDLE, wr_bank unchanged, no frame_start. A following valid frame writes the same bank starting at idx 0.
- NOP words interleaved between every command of a cnt=2 frame → identical writes and timing as the first scenario (shifted by the NOP cycles), no error.
- ck_rst asserted mid-LOAD after 1 write → all outputs 0 next cycle. A new cnt=1 frame writes addr {0,0} and commits to render_bank=0.
